csr_access_unit: RTL

//  Initiator side of the CSR register file; the file writes on negedge clk and reads combinationally.

---
 rtl/csr_access_unit_pkg.sv | 52 +++++
 rtl/csr_access_unit_if.sv | 72 +++++++
 rtl/csr_access_unit_alu.sv | 42 ++++
 rtl/csr_access_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared types for the CSR access unit: CSR addresses, funct3 encodings, FSM states.
// CSR_FFLAGS_ACC_EN adds the FP-flag flush states.
package csr_access_unit_pkg;

    localparam int XLEN     = 32;
    localparam int FFLAGS_W = 5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_FFLAGS  = 12'h001;
    localparam logic [11:0] CSR_FRM     = 12'h002;
    localparam logic [11:0] CSR_FCSR    = 12'h003;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RMW_RD   = 3'd1,
        S_RMW_WR   = 3'd2,
        S_TR_EPC   = 3'd3,
        S_TR_CAUSE = 3'd4,
`ifdef CSR_FFLAGS_ACC_EN
        S_TR_VAL   = 3'd5,
        S_FF_RD    = 3'd6,
        S_FF_WR    = 3'd7
`else
        S_TR_VAL   = 3'd5
`endif
    } csr_state_e;

    function automatic logic csr_implemented(input logic [11:0] a);
        logic hit;
        hit = 1'b0;
        unique case (a)
            CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
            CSR_MTVAL, CSR_FFLAGS, CSR_FRM, CSR_FCSR: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of request/response, trap and CSR-file port signals for the access unit.
// CSR_FFLAGS_ACC_EN adds fflags_valid/fflags.
interface csr_access_unit_if;
    import csr_access_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic            req_rs1_zero;
    logic [4:0]      req_zimm;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_illegal;

    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic            trap_done;
    logic [XLEN-1:0] trap_target;

    logic [11:0]     csr_address_r;
    logic [XLEN-1:0] csr_data_r;
    logic            csrW_en;
    logic [11:0]     csr_address_w;
    logic [XLEN-1:0] csr_data_w;

`ifdef CSR_FFLAGS_ACC_EN
    logic                fflags_valid;
    logic [FFLAGS_W-1:0] fflags;
`endif

    modport master (
`ifdef CSR_FFLAGS_ACC_EN
        output fflags_valid, output fflags,
`endif
        output req_valid, input req_ready,
        output req_funct3, output req_addr,
        output req_rs1_data, output req_rs1_zero,
        output req_zimm,
        input resp_valid, input resp_rdata,
        input resp_illegal,
        output trap_valid, output trap_pc,
        output trap_cause, output trap_tval,
        input trap_done, input trap_target,
        input csr_address_r, output csr_data_r,
        input csrW_en, input csr_address_w,
        input csr_data_w
    );

    modport slave (
`ifdef CSR_FFLAGS_ACC_EN
        input fflags_valid, input fflags,
`endif
        input req_valid, output req_ready,
        input req_funct3, input req_addr,
        input req_rs1_data, input req_rs1_zero,
        input req_zimm,
        output resp_valid, output resp_rdata,
        output resp_illegal,
        input trap_valid, input trap_pc,
        input trap_cause, input trap_tval,
        output trap_done, output trap_target,
        output csr_address_r, input csr_data_r,
        output csrW_en, output csr_address_w,
        output csr_data_w
    );

endinterface

// File: rtl/csr_access_unit_alu.sv
// Zicsr operand select, new-value compute and write-suppress decision.
// Purely combinational; legality of the op/address is handled by the caller.
module csr_alu
    import csr_access_unit_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic            rs1_zero_i,
    input  logic [4:0]      zimm_i,
    input  logic [XLEN-1:0] old_i,
    output logic [XLEN-1:0] new_o,
    output logic            write_o
);

    logic [XLEN-1:0] src;
    logic            src_zero;
    logic            is_rw;
    logic            is_rs;
    logic            is_rc;

    assign src = funct3_i[2] ? {{(XLEN-5){1'b0}}, zimm_i}
                             : rs1_data_i;
    assign src_zero = funct3_i[2] ? (zimm_i == 5'd0) : rs1_zero_i;

    assign is_rw = (funct3_i == OP_RW) || (funct3_i == OP_RWI);
    assign is_rs = (funct3_i == OP_RS) || (funct3_i == OP_RSI);
    assign is_rc = (funct3_i == OP_RC) || (funct3_i == OP_RCI);

    always_comb begin
        new_o = '0;
        unique case (1'b1)
            is_rw:   new_o = src;
            is_rs:   new_o = old_i | src;
            is_rc:   new_o = old_i & ~src;
            default: new_o = '0;
        endcase
    end

    // Set/clear with a zero source must not write (read-only CSR side effects).
    assign write_o = is_rw || ((is_rs || is_rc) && !src_zero);

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: Zicsr read-modify-write and machine trap entry via one read/write port.
// CSR_FFLAGS_ACC_EN enables sticky FP-flag accumulation and flush to fflags.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    csr_access_unit_if.slave bus
);

    csr_state_e      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic            rs1_zero_q, rs1_zero_d;
    logic [4:0]      zimm_q, zimm_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] new_q, new_d;
    logic            we_q, we_d;

    logic [XLEN-1:0] alu_new;
    logic            alu_write;

`ifdef CSR_FFLAGS_ACC_EN
    logic [FFLAGS_W-1:0] pend_q, pend_d;
    logic [FFLAGS_W-1:0] pend_in;

    assign pend_in = bus.fflags_valid ? bus.fflags : '0;
`endif

    csr_alu u_alu (
        .funct3_i   (funct3_q),
        .rs1_data_i (rs1_q),
        .rs1_zero_i (rs1_zero_q),
        .zimm_i     (zimm_q),
        .old_i      (bus.csr_data_r),
        .new_o      (alu_new),
        .write_o    (alu_write)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_q      <= '0;
            rs1_zero_q <= 1'b0;
            zimm_q     <= '0;
            illegal_q  <= 1'b0;
            old_q      <= '0;
            new_q      <= '0;
            we_q       <= 1'b0;
`ifdef CSR_FFLAGS_ACC_EN
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rs1_q      <= rs1_d;
            rs1_zero_q <= rs1_zero_d;
            zimm_q     <= zimm_d;
            illegal_q  <= illegal_d;
            old_q      <= old_d;
            new_q      <= new_d;
            we_q       <= we_d;
`ifdef CSR_FFLAGS_ACC_EN
            pend_q     <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        rs1_d      = rs1_q;
        rs1_zero_d = rs1_zero_q;
        zimm_d     = zimm_q;
        illegal_d  = illegal_q;
        old_d      = old_q;
        new_d      = new_q;
        we_d       = we_q;
`ifdef CSR_FFLAGS_ACC_EN
        pend_d     = pend_q | pend_in;
`endif

        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_rdata    = '0;
        bus.resp_illegal  = 1'b0;
        bus.trap_done     = 1'b0;
        bus.trap_target   = '0;
        bus.csr_address_r = '0;
        bus.csrW_en       = 1'b0;
        bus.csr_address_w = '0;
        bus.csr_data_w    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.trap_valid) begin
                    state_d = S_TR_EPC;
`ifdef CSR_FFLAGS_ACC_EN
                end else if (pend_q != '0) begin
                    state_d = S_FF_RD;
`endif
                end else begin
                    // Held low during reset so no output is active then.
                    bus.req_ready = rst;
                    if (bus.req_valid) begin
                        state_d    = S_RMW_RD;
                        funct3_d   = bus.req_funct3;
                        addr_d     = bus.req_addr;
                        rs1_d      = bus.req_rs1_data;
                        rs1_zero_d = bus.req_rs1_zero;
                        zimm_d     = bus.req_zimm;
                        illegal_d  = !csr_implemented(bus.req_addr)
                                  || (bus.req_funct3[1:0] == 2'b00);
                    end
                end
            end
            S_RMW_RD: begin
                bus.csr_address_r = addr_q;
                old_d   = illegal_q ? '0 : bus.csr_data_r;
                new_d   = alu_new;
                we_d    = alu_write && !illegal_q;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                bus.resp_valid   = 1'b1;
                bus.resp_rdata   = old_q;
                bus.resp_illegal = illegal_q;
                if (we_q) begin
                    bus.csrW_en       = 1'b1;
                    bus.csr_address_w = addr_q;
                    bus.csr_data_w    = new_q;
                end
                state_d = S_IDLE;
            end
            S_TR_EPC: begin
                bus.csrW_en       = 1'b1;
                bus.csr_address_w = CSR_MEPC;
                bus.csr_data_w    = bus.trap_pc;
                state_d           = S_TR_CAUSE;
            end
            S_TR_CAUSE: begin
                bus.csrW_en       = 1'b1;
                bus.csr_address_w = CSR_MCAUSE;
                bus.csr_data_w    = bus.trap_cause;
                state_d           = S_TR_VAL;
            end
            S_TR_VAL: begin
                bus.csrW_en       = 1'b1;
                bus.csr_address_w = CSR_MTVAL;
                bus.csr_data_w    = bus.trap_tval;
                bus.csr_address_r = CSR_MTVEC;
                bus.trap_done     = 1'b1;
                bus.trap_target   = {bus.csr_data_r[XLEN-1:2], 2'b00};
                state_d           = S_IDLE;
            end
`ifdef CSR_FFLAGS_ACC_EN
            S_FF_RD: begin
                bus.csr_address_r = CSR_FFLAGS;
                old_d             = bus.csr_data_r;
                state_d           = S_FF_WR;
            end
            S_FF_WR: begin
                bus.csrW_en       = 1'b1;
                bus.csr_address_w = CSR_FFLAGS;
                bus.csr_data_w    = {{(XLEN-FFLAGS_W){1'b0}},
                                     old_q[FFLAGS_W-1:0] | pend_q};
                // Flags landing this cycle stay pending for the next flush.
                pend_d            = pend_in;
                state_d           = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule
